// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : menu_pkg
//  Purpose : Shared types and constants for the keyboard-driven menu
//            controller: FSM state encoding, default HID usage codes and
//            the index-width helper used to size menu_num / game_mode.
//  Revision: 1.0 - initial release
// ============================================================================
package menu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BROWSE  = 2'd1,
    LAUNCH  = 2'd2,
    PLAYING = 2'd3
  } menu_state_t;

  // USB HID keyboard usage codes
  localparam logic [7:0] KEY_UP_DEF    = 8'h52;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h51;
  localparam logic [7:0] KEY_ENTER_DEF = 8'h58;
  localparam logic [7:0] KEY_ESC_DEF   = 8'h29;

  // Width able to hold 0 (nothing highlighted) through n (last entry).
  function automatic int idx_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_detect.sv
`default_nettype none
// ============================================================================
//  Module  : frame_tick_detect
//  Purpose : Brings the asynchronous frame strobe into the clk domain and
//            produces a one-clock tick on each synchronised rising edge.
//            The tick is registered, so it appears 3 clocks after the
//            strobe rises.
//  Ports   : clk       - system clock
//            rst_n     - asynchronous active-low reset
//            level_in  - asynchronous frame strobe level
//            tick      - one-clock pulse per strobe rising edge
//  Revision: 1.0 - initial release
// ============================================================================
module frame_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  output logic tick
);

  logic sync_0;
  logic sync_1;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      sync_prev <= 1'b0;
      tick      <= 1'b0;
    end else begin
      sync_0    <= level_in;
      sync_1    <= sync_0;
      sync_prev <= sync_1;
      tick      <= sync_1 & ~sync_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/menu_select.sv
`default_nettype none
// ============================================================================
//  Module  : menu_select
//  Purpose : Keyboard-driven menu controller. Tracks the highlighted entry
//            among NUM_ITEMS options, positions the highlight box, pulses
//            start_game with the chosen mode on Enter, hides the menu while
//            playing and re-opens it on Escape. Keys are sampled once per
//            video frame, and only a change to a non-zero keycode acts.
//  Ports   : Clk          - 50 MHz system clock
//            Reset_n      - asynchronous active-low reset
//            frame_clk    - ~60 Hz frame strobe (asynchronous level)
//            keycode      - currently pressed key, 0 = none
//            menu_num     - 0 = nothing highlighted, k = entry k
//            menu_visible - 1 while the menu is drawn
//            start_game   - one-clock pulse on confirm
//            game_mode    - 0-based selected entry, held until next confirm
//            menuboxX/Y   - highlight box top-left corner
//  Revision: 1.0 - initial release
// ============================================================================
module menu_select
  import menu_pkg::*;
#(
  parameter int         NUM_ITEMS  = 2,
  parameter bit         WRAP       = 1'b1,
  parameter logic [9:0] BOX_X0     = 10'd220,
  parameter logic [9:0] BOX_Y0     = 10'd200,
  parameter logic [9:0] ITEM_PITCH = 10'd40,
  parameter logic [7:0] KEY_UP     = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN   = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_ENTER  = KEY_ENTER_DEF,
  parameter logic [7:0] KEY_ESC    = KEY_ESC_DEF,
  localparam int        IDX_W      = idx_width(NUM_ITEMS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic [7:0]       keycode,
  output logic [IDX_W-1:0] menu_num,
  output logic             menu_visible,
  output logic             start_game,
  output logic [IDX_W-1:0] game_mode,
  output logic [9:0]       menuboxX,
  output logic [9:0]       menuboxY
);

  localparam logic [IDX_W-1:0] FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_ITEMS);

  // Lowest entry must still fit on the 480-line screen.
  if (NUM_ITEMS < 1 ||
      int'(BOX_Y0) + (NUM_ITEMS - 1) * int'(ITEM_PITCH) > 479) begin : g_bad_geometry
    $error("menu_select: NUM_ITEMS/BOX_Y0/ITEM_PITCH place an entry off screen");
  end

  logic             tick;
  logic             press;
  logic [7:0]       key_prev;
  menu_state_t      state, state_d;
  logic [IDX_W-1:0] num_d;
  logic [IDX_W-1:0] mode_d;
  logic [9:0]       idx_off;

  frame_tick_detect u_tick (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .level_in (frame_clk),
    .tick     (tick)
  );

  // A held key matches key_prev on later ticks, so it acts only once.
  assign press = tick && (keycode != key_prev) && (keycode != 8'h00);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      menu_num   <= '0;
      game_mode  <= '0;
      start_game <= 1'b0;
      key_prev   <= 8'h00;
    end else begin
      state      <= state_d;
      menu_num   <= num_d;
      game_mode  <= mode_d;
      start_game <= (state_d == LAUNCH);
      if (tick) begin
        key_prev <= keycode;
      end
    end
  end

  always_comb begin
    state_d = state;
    num_d   = menu_num;
    mode_d  = game_mode;
    case (state)
      IDLE: begin
        if (press && keycode == KEY_DOWN) begin
          num_d   = FIRST;
          state_d = BROWSE;
        end else if (press && keycode == KEY_UP) begin
          num_d   = LAST;
          state_d = BROWSE;
        end
      end
      BROWSE: begin
        if (press) begin
          if (keycode == KEY_DOWN) begin
            if (menu_num == LAST) begin
              num_d = WRAP ? FIRST : LAST;
            end else begin
              num_d = menu_num + IDX_W'(1);
            end
          end else if (keycode == KEY_UP) begin
            if (menu_num == FIRST) begin
              num_d = WRAP ? LAST : FIRST;
            end else begin
              num_d = menu_num - IDX_W'(1);
            end
          end else if (keycode == KEY_ENTER) begin
            // Capture the mode on entry so it is valid alongside start_game.
            mode_d  = menu_num - IDX_W'(1);
            state_d = LAUNCH;
          end else if (keycode == KEY_ESC) begin
            num_d   = '0;
            state_d = IDLE;
          end
        end
      end
      LAUNCH: begin
        state_d = PLAYING;
      end
      PLAYING: begin
        if (press && keycode == KEY_ESC) begin
          state_d = BROWSE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign menu_visible = (state != PLAYING);

  always_comb begin
    menuboxX = 10'd0;
    menuboxY = 10'd0;
    idx_off  = 10'(menu_num) - 10'd1;
    if (menu_num != '0) begin
      menuboxX = BOX_X0;
      menuboxY = BOX_Y0 + idx_off * ITEM_PITCH;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_menu_select.sv
`default_nettype none
// ============================================================================
//  Module  : tb_menu_select
//  Purpose : Self-checking bench for menu_select. Two instances (WRAP=1 and
//            WRAP=0, NUM_ITEMS=3) share all inputs; a vector table drives
//            one frame per entry, followed by hand-written sequences for
//            launch, play, escape, between-tick glitches and reset.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_menu_select;

  localparam logic [7:0] K_UP  = 8'h52;
  localparam logic [7:0] K_DN  = 8'h51;
  localparam logic [7:0] K_ENT = 8'h58;
  localparam logic [7:0] K_ESC = 8'h29;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;

  logic [1:0] num_w, num_s, gm_w, gm_s;
  logic       vis_w, vis_s, start_w, start_s;
  logic [9:0] bx_w, by_w, bx_s, by_s;

  int checks   = 0;
  int failures = 0;
  int pc_w     = 0;
  int pc_s     = 0;
  logic [1:0] gm_pulse_w = '0;

  menu_select #(.NUM_ITEMS(3), .WRAP(1'b1)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .menu_num(num_w), .menu_visible(vis_w), .start_game(start_w),
    .game_mode(gm_w), .menuboxX(bx_w), .menuboxY(by_w)
  );

  menu_select #(.NUM_ITEMS(3), .WRAP(1'b0)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .menu_num(num_s), .menu_visible(vis_s), .start_game(start_s),
    .game_mode(gm_s), .menuboxX(bx_s), .menuboxY(by_s)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Count start_game pulses (one negedge per high cycle).
  always @(negedge Clk) begin
    if (start_w) begin
      pc_w       <= pc_w + 1;
      gm_pulse_w <= gm_w;
    end
    if (start_s) pc_s <= pc_s + 1;
  end

  typedef struct {
    logic [7:0] key;
    logic [1:0] num_w;
    logic [1:0] num_s;
    logic [9:0] y_w;
    logic [9:0] y_s;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full frame strobe with keycode held stable throughout.
  task automatic frame(input logic [7:0] k);
    keycode = k;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic check_both(input string tag, input logic [1:0] n, input logic vis, input logic [9:0] y);
    check({tag, " num_w"}, 32'(num_w), 32'(n));
    check({tag, " num_s"}, 32'(num_s), 32'(n));
    check({tag, " vis_w"}, 32'(vis_w), 32'(vis));
    check({tag, " vis_s"}, 32'(vis_s), 32'(vis));
    check({tag, " y_w"},   32'(by_w),  32'(y));
    check({tag, " x_w"},   32'(bx_w),  (n == 2'd0) ? 32'd0 : 32'd220);
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{K_ENT, 2'd0, 2'd0, 10'd0,   10'd0};
    vecs[1]  = '{8'h00, 2'd0, 2'd0, 10'd0,   10'd0};
    vecs[2]  = '{K_ESC, 2'd0, 2'd0, 10'd0,   10'd0};
    vecs[3]  = '{8'h00, 2'd0, 2'd0, 10'd0,   10'd0};
    vecs[4]  = '{K_DN,  2'd1, 2'd1, 10'd200, 10'd200};
    vecs[5]  = '{K_DN,  2'd1, 2'd1, 10'd200, 10'd200};
    vecs[6]  = '{K_DN,  2'd1, 2'd1, 10'd200, 10'd200};
    vecs[7]  = '{K_DN,  2'd1, 2'd1, 10'd200, 10'd200};
    vecs[8]  = '{K_DN,  2'd1, 2'd1, 10'd200, 10'd200};
    vecs[9]  = '{8'h00, 2'd1, 2'd1, 10'd200, 10'd200};
    vecs[10] = '{K_DN,  2'd2, 2'd2, 10'd240, 10'd240};
    vecs[11] = '{8'h00, 2'd2, 2'd2, 10'd240, 10'd240};
    vecs[12] = '{K_DN,  2'd3, 2'd3, 10'd280, 10'd280};
    vecs[13] = '{8'h00, 2'd3, 2'd3, 10'd280, 10'd280};
    vecs[14] = '{K_DN,  2'd1, 2'd3, 10'd200, 10'd280};
    vecs[15] = '{8'h00, 2'd1, 2'd3, 10'd200, 10'd280};
    vecs[16] = '{K_UP,  2'd3, 2'd2, 10'd280, 10'd240};
    vecs[17] = '{8'h00, 2'd3, 2'd2, 10'd280, 10'd240};
    vecs[18] = '{K_UP,  2'd2, 2'd1, 10'd240, 10'd200};
    vecs[19] = '{8'h00, 2'd2, 2'd1, 10'd240, 10'd200};
    vecs[20] = '{K_UP,  2'd1, 2'd1, 10'd200, 10'd200};
    vecs[21] = '{8'h00, 2'd1, 2'd1, 10'd200, 10'd200};
    vecs[22] = '{8'h04, 2'd1, 2'd1, 10'd200, 10'd200};
    vecs[23] = '{8'h00, 2'd1, 2'd1, 10'd200, 10'd200};
    vecs[24] = '{K_DN,  2'd2, 2'd2, 10'd240, 10'd240};
    vecs[25] = '{8'h00, 2'd2, 2'd2, 10'd240, 10'd240};

    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    #5;
    check_both("reset", 2'd0, 1'b1, 10'd0);
    check("reset start_w", 32'(start_w), 32'd0);
    check("reset gm_w",    32'(gm_w),    32'd0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 26; i++) begin
      frame(vecs[i].key);
      check($sformatf("v%0d num_w", i), 32'(num_w), 32'(vecs[i].num_w));
      check($sformatf("v%0d num_s", i), 32'(num_s), 32'(vecs[i].num_s));
      check($sformatf("v%0d y_w", i),   32'(by_w),  32'(vecs[i].y_w));
      check($sformatf("v%0d y_s", i),   32'(by_s),  32'(vecs[i].y_s));
      check($sformatf("v%0d x_w", i),   32'(bx_w),  (vecs[i].num_w == 2'd0) ? 32'd0 : 32'd220);
      check($sformatf("v%0d vis_w", i), 32'(vis_w), 32'd1);
    end
    check("idle enter no pulse w", 32'(pc_w), 32'd0);
    check("idle enter no pulse s", 32'(pc_s), 32'd0);

    // Launch from entry 2
    frame(K_ENT);
    check("launch pulses w", 32'(pc_w), 32'd1);
    check("launch pulses s", 32'(pc_s), 32'd1);
    check("launch gm at pulse", 32'(gm_pulse_w), 32'd1);
    check("launch gm_w", 32'(gm_w), 32'd1);
    check("launch gm_s", 32'(gm_s), 32'd1);
    check_both("playing", 2'd2, 1'b0, 10'd240);
    frame(8'h00);
    frame(K_UP);
    frame(8'h00);
    frame(K_DN);
    frame(8'h00);
    frame(K_ENT);
    frame(8'h00);
    check_both("playing keys", 2'd2, 1'b0, 10'd240);
    check("playing enter no pulse", 32'(pc_w), 32'd1);

    // Escape back to the menu, then out to idle
    frame(K_ESC);
    check_both("esc to browse", 2'd2, 1'b1, 10'd240);
    frame(8'h00);
    frame(K_ESC);
    check_both("esc to idle", 2'd0, 1'b1, 10'd0);
    frame(8'h00);
    frame(K_ENT);
    frame(8'h00);
    check("idle enter again", 32'(pc_w), 32'd1);
    check_both("idle after enter", 2'd0, 1'b1, 10'd0);

    // Key pulse strictly between ticks
    keycode = K_DN;
    repeat (1000) @(negedge Clk);
    keycode = 8'h00;
    repeat (2) @(negedge Clk);
    frame(8'h00);
    check_both("between ticks", 2'd0, 1'b1, 10'd0);

    // Up from idle lands on the last entry
    frame(K_UP);
    check_both("idle up", 2'd3, 1'b1, 10'd280);
    frame(8'h00);

    // Reset asserted while in LAUNCH
    keycode = K_ENT;
    @(negedge Clk);
    frame_clk = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge Clk);
      #1;
      if (start_w) seen = 1'b1;
    end
    check("launch seen before reset", 32'(seen), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("rst in launch start_w", 32'(start_w), 32'd0);
    check("rst in launch start_s", 32'(start_s), 32'd0);
    check("rst in launch gm_w",    32'(gm_w),    32'd0);
    check_both("rst in launch", 2'd0, 1'b1, 10'd0);
    frame_clk = 1'b0;
    keycode   = 8'h00;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check_both("after release", 2'd0, 1'b1, 10'd0);
    check("no pulse after reset", 32'(pc_w), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
